// File: rtl/gf180mcu_fd_sc_mcu7t5v0__prbs_xnor_chk.sv
// Serial PRBS checker with an XNOR-feedback LFSR predictor.
// Self-seeds from the received stream, verifies lock, then flags and counts bit errors.
module gf180mcu_fd_sc_mcu7t5v0__prbs_xnor_chk #(
  parameter int WIDTH      = 7,
  parameter int TAP_A      = 7,
  parameter int TAP_B      = 6,
  parameter int LOCK_THR   = 16,
  parameter int UNLOCK_THR = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             clr,
  output logic             lock,
  output logic             err,
  output logic [CNT_W-1:0] errcnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(LOCK_THR + 1);
  localparam int BW = $clog2(UNLOCK_THR + 1);

  if (WIDTH < 3 || WIDTH > 32 || TAP_B < 1 || TAP_B >= TAP_A || TAP_A > WIDTH) begin : g_bad_params
    $error("prbs_xnor_chk: illegal WIDTH/TAP_A/TAP_B combination");
  end

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state;
  logic [WIDTH-1:0] s;
  logic [FW-1:0]    fill_cnt;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;

  logic             pred;
  logic             mismatch;
  logic [WIDTH-1:0] s_fill;
  logic [WIDTH-1:0] s_pred;
  logic [FW-1:0]    fill_inc;
  logic [GW-1:0]    good_inc;
  logic [BW-1:0]    bad_inc;
  logic             errcnt_sat;

  assign pred       = ~(s[TAP_A-1] ^ s[TAP_B-1]);
  assign mismatch   = d ^ pred;
  assign s_fill     = {s[WIDTH-2:0], d};
  assign s_pred     = {s[WIDTH-2:0], pred};
  assign fill_inc   = fill_cnt + FW'(1);
  assign good_inc   = good_cnt + GW'(1);
  assign bad_inc    = bad_cnt + BW'(1);
  assign errcnt_sat = &errcnt;

  // Once past HUNT the local LFSR free-runs on its own prediction, so line errors never corrupt it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      s        <= '0;
      fill_cnt <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      lock     <= 1'b0;
      err      <= 1'b0;
      errcnt   <= '0;
    end else begin
      err <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            s <= s_fill;
            if (fill_inc == FW'(WIDTH)) begin
              fill_cnt <= '0;
              if (!(&s_fill)) begin
                state    <= VERIFY;
                good_cnt <= '0;
              end
            end else begin
              fill_cnt <= fill_inc;
            end
          end
          VERIFY: begin
            s <= s_pred;
            if (!mismatch) begin
              good_cnt <= good_inc;
              if (good_inc == GW'(LOCK_THR)) begin
                state   <= LOCKED;
                lock    <= 1'b1;
                bad_cnt <= '0;
              end
            end else begin
              state    <= HUNT;
              fill_cnt <= '0;
            end
          end
          LOCKED: begin
            s <= s_pred;
            if (mismatch) begin
              err <= 1'b1;
              if (!errcnt_sat) errcnt <= errcnt + CNT_W'(1);
              bad_cnt <= bad_inc;
              if (bad_inc == BW'(UNLOCK_THR)) begin
                state    <= HUNT;
                fill_cnt <= '0;
                lock     <= 1'b0;
              end
            end else begin
              bad_cnt <= '0;
            end
          end
          default: begin
            state    <= HUNT;
            fill_cnt <= '0;
            lock     <= 1'b0;
          end
        endcase
      end
      // Clear wins over a same-cycle increment; the ERR pulse is unaffected.
      if (clr) errcnt <= '0;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__prbs_xnor_chk.sv
// Directed bench for the XNOR PRBS checker: a vector table plus hand-written lock/error sequences.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_gf180mcu_fd_sc_mcu7t5v0__prbs_xnor_chk;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        d   = 1'b0;
  logic        clr = 1'b0;
  logic        lock, err;
  logic [15:0] errcnt;
  logic        lock4, err4;
  logic [3:0]  errcnt4;

  int vecs = 0;
  int miss = 0;
  logic [6:0] txs;

  typedef struct {
    logic       rst, en, d, clr;
    logic       lock, err;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  gf180mcu_fd_sc_mcu7t5v0__prbs_xnor_chk dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr),
    .lock(lock), .err(err), .errcnt(errcnt)
  );

  gf180mcu_fd_sc_mcu7t5v0__prbs_xnor_chk #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr),
    .lock(lock4), .err(err4), .errcnt(errcnt4)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic r, input logic e, input logic b, input logic c);
    rst = r; en = e; d = b; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic el, input logic ee, input int ec);
    logic [3:0] ec4;
    ec4 = (ec > 15) ? 4'd15 : 4'(ec);
    vecs++;
    if (lock !== el || err !== ee || errcnt !== 16'(ec) ||
        lock4 !== el || err4 !== ee || errcnt4 !== ec4) begin
      miss++;
      $display("[TB] FAIL %s: got lock=%b err=%b errcnt=%0d lock4=%b err4=%b errcnt4=%0d, expected lock=%b err=%b errcnt=%0d errcnt4=%0d",
               nm, lock, err, errcnt, lock4, err4, errcnt4, el, ee, ec, ec4);
    end
  endtask

  task automatic addVec(input logic r, input logic e, input logic b, input logic c,
                        input logic el, input logic ee, input int ec);
    vec_t v;
    v.rst = r; v.en = e; v.d = b; v.clr = c;
    v.lock = el; v.err = ee; v.cnt = 16'(ec);
    tbl.push_back(v);
  endtask

  task automatic nextBit(output logic b);
    b   = ~(txs[6] ^ txs[5]);
    txs = {txs[5:0], b};
  endtask

  task automatic idleGaps(input string nm, input logic el, input int ec);
    int n;
    logic r;
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      r = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, 1'b0, r, 1'b0);
      checkOutput(nm, el, 1'b0, ec);
    end
  endtask

  // Sends n correct bits of the reference stream; lock is expected only after the last one.
  task automatic sendStream(input string nm, input int n, input int ec, input bit gaps);
    logic b;
    for (int i = 0; i < n; i++) begin
      nextBit(b);
      applyStimulus(1'b0, 1'b1, b, 1'b0);
      checkOutput(nm, i == n - 1, 1'b0, ec);
      if (gaps) idleGaps(nm, i == n - 1, ec);
    end
  endtask

  task automatic sendZeroSeed(input string nm, input int ec, input bit gaps);
    txs = '0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput(nm, 1'b0, 1'b0, ec);
      if (gaps) idleGaps(nm, 1'b0, ec);
    end
  endtask

  task automatic sendGood(input string nm, input logic el, input int ec, input logic c);
    logic b;
    nextBit(b);
    applyStimulus(1'b0, 1'b1, b, c);
    checkOutput(nm, el, 1'b0, ec);
  endtask

  task automatic sendErr(input string nm, input logic el, input int ec, input logic c);
    logic b;
    nextBit(b);
    applyStimulus(1'b0, 1'b1, ~b, c);
    checkOutput(nm, el, 1'b1, ec);
  endtask

  initial begin
    logic [15:0] prbs16;
    logic        b;
    prbs16 = 16'b1111_1101_1111_0011;

    // Reset, lockup-seed rejection, zero seed, hand-computed PRBS7 lock, one error, clear.
    addVec(1, 1, 1, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) addVec(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) addVec(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) addVec(0, 1, prbs16[15-i], 0, i == 15, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 0);
    addVec(0, 1, 0, 0, 1, 1, 1);
    addVec(0, 1, 1, 0, 1, 0, 1);
    addVec(0, 1, 0, 1, 1, 0, 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].d, tbl[i].clr);
      checkOutput($sformatf("table[%0d]", i), tbl[i].lock, tbl[i].err, int'(tbl[i].cnt));
    end

    // Continuous ones never leave HUNT.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("ones_reset", 1'b0, 1'b0, 0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("ones_hunt", 1'b0, 1'b0, 0);
    end

    // Zero seed plus PRBS7 continuation with random idle gaps.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_reset", 1'b0, 1'b0, 0);
    sendZeroSeed("t1_seed", 0, 1'b1);
    sendStream("t1_lock", 16, 0, 1'b1);

    // Single inverted bit.
    sendErr("t3_err", 1'b1, 1, 1'b0);
    sendGood("t3_after", 1'b1, 1, 1'b0);
    sendGood("t3_hold", 1'b1, 1, 1'b0);

    // Four consecutive errors drop lock; the stream then relocks.
    sendGood("t4_clr", 1'b1, 0, 1'b1);
    for (int k = 1; k <= 4; k++) sendErr("t4_burst", k < 4, k, 1'b0);
    sendStream("t4_relock", 23, 4, 1'b1);

    // Isolated errors: the 4-bit instance saturates at 15.
    sendGood("t5_clr", 1'b1, 0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      sendErr("t5_err", 1'b1, k, 1'b0);
      sendGood("t5_good", 1'b1, k, 1'b0);
    end
    sendErr("t5_clr_err", 1'b1, 0, 1'b1);
    sendGood("t5_post", 1'b1, 0, 1'b0);

    // Reset while locked with a nonzero count, on an erroneous bit.
    for (int k = 1; k <= 3; k++) begin
      sendErr("t6_err", 1'b1, k, 1'b0);
      sendGood("t6_good", 1'b1, k, 1'b0);
    end
    nextBit(b);
    applyStimulus(1'b1, 1'b1, ~b, 1'b0);
    checkOutput("t6_reset", 1'b0, 1'b0, 0);
    sendZeroSeed("t6_seed", 0, 1'b0);
    sendStream("t6_relock", 16, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
